// File: rtl/pipeline_pkg.sv
// Shared types and constants for the register-read/issue stage and its scoreboard.
package pipeline_pkg;

  localparam int unsigned DefDataWidth    = 64;
  localparam int unsigned DefPcWidth      = 64;
  localparam int unsigned DefRegAmountLog = 5;
  localparam int unsigned REG_COUNT       = 2 ** DefRegAmountLog;

  // Registered operand bundle handed to execute.
  typedef struct packed {
    logic [DefPcWidth-1:0]      pc;
    logic [DefDataWidth-1:0]    rs1_val;
    logic [DefDataWidth-1:0]    rs2_val;
    logic [DefRegAmountLog-1:0] rd;
    logic                       writes_rd;
  } issue_bundle_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback or when a flushed write is dropped.
module reg_scoreboard
  import pipeline_pkg::*;
#(
  parameter int unsigned REGISTER_AMOUNT_LOG = DefRegAmountLog
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           set_valid,
  input  logic [REGISTER_AMOUNT_LOG-1:0] set_reg,
  input  logic                           clr_valid,
  input  logic [REGISTER_AMOUNT_LOG-1:0] clr_reg,
  input  logic                           flush_clr_valid,
  input  logic [REGISTER_AMOUNT_LOG-1:0] flush_clr_reg,
  input  logic [REGISTER_AMOUNT_LOG-1:0] lookup_rs1,
  input  logic [REGISTER_AMOUNT_LOG-1:0] lookup_rs2,
  input  logic [REGISTER_AMOUNT_LOG-1:0] lookup_rd,
  output logic                           busy_rs1,
  output logic                           busy_rs2,
  output logic                           busy_rd
);

  localparam int unsigned NumRegs = 2 ** REGISTER_AMOUNT_LOG;

  logic [NumRegs-1:0] busy_d, busy_q;

  always_comb begin
    busy_d = busy_q;
    if (clr_valid)       busy_d[clr_reg]       = 1'b0;
    if (flush_clr_valid) busy_d[flush_clr_reg] = 1'b0;
    // Applied last so an issue and a writeback to the same register leave it busy.
    if (set_valid)       busy_d[set_reg]       = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_rs1 = busy_q[lookup_rs1];
  assign busy_rs2 = busy_q[lookup_rs2];
  assign busy_rd  = busy_q[lookup_rd];

endmodule

// File: rtl/reg_read_stage.sv
// Register-read/issue stage: reads operands with writeback bypass, stalls on RAW/WAW
// hazards and holds the issued bundle in a valid/ready output register.
module reg_read_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = DefDataWidth,
  parameter int unsigned REGISTER_AMOUNT_LOG = DefRegAmountLog,
  parameter int unsigned PC_WIDTH            = DefPcWidth
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PC_WIDTH-1:0]            in_pc,
  input  logic [REGISTER_AMOUNT_LOG-1:0] in_rs1,
  input  logic [REGISTER_AMOUNT_LOG-1:0] in_rs2,
  input  logic [REGISTER_AMOUNT_LOG-1:0] in_rd,
  input  logic                           in_writes_rd,
  output logic [REGISTER_AMOUNT_LOG-1:0] rf_read1,
  output logic [REGISTER_AMOUNT_LOG-1:0] rf_read2,
  input  logic [DATA_WIDTH-1:0]          rf_out1,
  input  logic [DATA_WIDTH-1:0]          rf_out2,
  output logic [REGISTER_AMOUNT_LOG-1:0] rf_write_reg,
  output logic [DATA_WIDTH-1:0]          rf_write_data,
  input  logic                           wb_valid,
  input  logic [REGISTER_AMOUNT_LOG-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]          wb_data,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PC_WIDTH-1:0]            out_pc,
  output logic [DATA_WIDTH-1:0]          out_rs1_val,
  output logic [DATA_WIDTH-1:0]          out_rs2_val,
  output logic [REGISTER_AMOUNT_LOG-1:0] out_rd,
  output logic                           out_writes_rd
);

  issue_bundle_t bundle_d, bundle_q;
  logic          out_valid_d, out_valid_q;

  logic busy_rs1, busy_rs2, busy_rd;
  logic byp1, byp2;
  logic src_ok1, src_ok2, dst_ok, space, fire;
  logic [DATA_WIDTH-1:0] op1, op2;
  logic sb_set, sb_clr, sb_flush_clr;

  assign rf_read1      = in_rs1;
  assign rf_read2      = in_rs2;
  // Idle cycles become a harmless write to x0.
  assign rf_write_reg  = wb_valid ? wb_rd : '0;
  assign rf_write_data = wb_valid ? wb_data : '0;

  assign byp1 = wb_valid && (wb_rd != '0) && (wb_rd == in_rs1);
  assign byp2 = wb_valid && (wb_rd != '0) && (wb_rd == in_rs2);
  assign op1  = byp1 ? wb_data : ((in_rs1 == '0) ? '0 : rf_out1);
  assign op2  = byp2 ? wb_data : ((in_rs2 == '0) ? '0 : rf_out2);

  assign src_ok1 = !busy_rs1 || byp1;
  assign src_ok2 = !busy_rs2 || byp2;
  assign dst_ok  = !in_writes_rd || (in_rd == '0) || !busy_rd || (wb_valid && (wb_rd == in_rd));
  assign space   = !out_valid_q || out_ready;

  assign in_ready = space && src_ok1 && src_ok2 && dst_ok && !flush && !reset;
  assign fire     = in_valid && in_ready;

  assign sb_set       = fire && in_writes_rd && (in_rd != '0);
  assign sb_clr       = wb_valid && (wb_rd != '0);
  // A flushed bundle's write will never come back, so release its destination.
  assign sb_flush_clr = flush && out_valid_q && bundle_q.writes_rd && (bundle_q.rd != '0);

  reg_scoreboard #(
    .REGISTER_AMOUNT_LOG(REGISTER_AMOUNT_LOG)
  ) u_scoreboard (
    .clk            (clk),
    .reset          (reset),
    .set_valid      (sb_set),
    .set_reg        (in_rd),
    .clr_valid      (sb_clr),
    .clr_reg        (wb_rd),
    .flush_clr_valid(sb_flush_clr),
    .flush_clr_reg  (bundle_q.rd),
    .lookup_rs1     (in_rs1),
    .lookup_rs2     (in_rs2),
    .lookup_rd      (in_rd),
    .busy_rs1       (busy_rs1),
    .busy_rs2       (busy_rs2),
    .busy_rd        (busy_rd)
  );

  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      bundle_d.pc        = in_pc;
      bundle_d.rs1_val   = op1;
      bundle_d.rs2_val   = op2;
      bundle_d.rd        = in_rd;
      bundle_d.writes_rd = in_writes_rd;
      out_valid_d        = 1'b1;
    end else if (space) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = bundle_q.pc;
  assign out_rs1_val   = bundle_q.rs1_val;
  assign out_rs2_val   = bundle_q.rs2_val;
  assign out_rd        = bundle_q.rd;
  assign out_writes_rd = bundle_q.writes_rd;

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage: a hazard-free vector table plus hand-written hazard sequences.
module tb_reg_read_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_writes_rd;
  logic [4:0]  rf_read1, rf_read2;
  logic [63:0] rf_out1, rf_out2;
  logic [4:0]  rf_write_reg;
  logic [63:0] rf_write_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc, out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_writes_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_read_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .in_writes_rd (in_writes_rd),
    .rf_read1     (rf_read1),
    .rf_read2     (rf_read2),
    .rf_out1      (rf_out1),
    .rf_out2      (rf_out2),
    .rf_write_reg (rf_write_reg),
    .rf_write_data(rf_write_data),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rs1_val  (out_rs1_val),
    .out_rs2_val  (out_rs2_val),
    .out_rd       (out_rd),
    .out_writes_rd(out_writes_rd)
  );

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [63:0] rf1, rf2;
    logic        wbv;
    logic [4:0]  wbr;
    logic [63:0] wbd;
    logic        exp_ready;
    logic [4:0]  exp_wreg;
    logic [63:0] exp_wdata;
    logic [63:0] exp_op1, exp_op2;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_writes_rd = 0;
    rf_out1 = '0; rf_out2 = '0; wb_valid = 0; wb_rd = '0; wb_data = '0; flush = 0;
    out_ready = 1;
  endtask

  task automatic issue(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wr);
    in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_writes_rd = wr;
  endtask

  initial begin
    vecs[0] = '{5'd1, 5'd2, 64'h11, 64'h22, 1'b0, 5'd0, 64'h0,
                1'b1, 5'd0, 64'h0, 64'h11, 64'h22};
    vecs[1] = '{5'd3, 5'd3, 64'hA, 64'hB, 1'b1, 5'd3, 64'h99,
                1'b1, 5'd3, 64'h99, 64'h99, 64'h99};
    vecs[2] = '{5'd0, 5'd4, 64'h55, 64'h44, 1'b1, 5'd0, 64'h1234,
                1'b1, 5'd0, 64'h1234, 64'h0, 64'h44};
    vecs[3] = '{5'd6, 5'd0, 64'h66, 64'h77, 1'b1, 5'd8, 64'h88,
                1'b1, 5'd8, 64'h88, 64'h66, 64'h0};
    vecs[4] = '{5'd31, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 5'd31, 64'h5,
                1'b1, 5'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};

    clear_inputs();
    reset = 1;
    issue(64'h40, 5'd0, 5'd0, 5'd3, 1'b1);
    tick();
    tick();
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_pc", out_pc, 0);
    check("reset_out_rd", out_rd, 0);
    clear_inputs();
    reset = 0;
    #1;
    check("post_reset_in_ready", in_ready, 1);
    tick();

    // Hazard-free table: no destination writes, so the scoreboard stays empty.
    for (int i = 0; i < 5; i++) begin
      issue(64'h1000 + 64'(i * 4), vecs[i].rs1, vecs[i].rs2, 5'd0, 1'b0);
      rf_out1 = vecs[i].rf1; rf_out2 = vecs[i].rf2;
      wb_valid = vecs[i].wbv; wb_rd = vecs[i].wbr; wb_data = vecs[i].wbd;
      #1;
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].exp_ready);
      check($sformatf("v%0d_rf_write_reg", i), rf_write_reg, vecs[i].exp_wreg);
      check($sformatf("v%0d_rf_write_data", i), rf_write_data, vecs[i].exp_wdata);
      check($sformatf("v%0d_rf_read1", i), rf_read1, vecs[i].rs1);
      tick();
      check($sformatf("v%0d_out_valid", i), out_valid, 1);
      check($sformatf("v%0d_out_pc", i), out_pc, 64'h1000 + 64'(i * 4));
      check($sformatf("v%0d_out_rs1", i), out_rs1_val, vecs[i].exp_op1);
      check($sformatf("v%0d_out_rs2", i), out_rs2_val, vecs[i].exp_op2);
    end
    clear_inputs();
    tick();
    check("idle_out_valid", out_valid, 0);

    // RAW on x5 resolved by writeback bypass, then read from the register file.
    issue(64'h100, 5'd0, 5'd0, 5'd5, 1'b1);
    #1 check("raw_first_ready", in_ready, 1);
    tick();
    issue(64'h104, 5'd5, 5'd0, 5'd0, 1'b0);
    #1 check("raw_stall", in_ready, 0);
    tick();
    wb_valid = 1; wb_rd = 5'd5; wb_data = 64'hDEAD;
    #1 check("raw_bypass_ready", in_ready, 1);
    check("raw_wb_reg", rf_write_reg, 5);
    tick();
    check("raw_out_rs1", out_rs1_val, 64'hDEAD);
    check("raw_out_pc", out_pc, 64'h104);
    wb_valid = 0; rf_out1 = 64'hDEAD; in_pc = 64'h108;
    #1 check("raw_busy_cleared", in_ready, 1);
    tick();
    check("raw_rf_read", out_rs1_val, 64'hDEAD);
    clear_inputs();

    // WAW on x7, then same-cycle set/clear of x7 must leave it busy.
    issue(64'h110, 5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    in_pc = 64'h114;
    #1 check("waw_stall_a", in_ready, 0);
    tick();
    check("waw_stall_b", in_ready, 0);
    wb_valid = 1; wb_rd = 5'd7; wb_data = 64'h77;
    #1 check("waw_release", in_ready, 1);
    tick();
    check("waw_out_pc", out_pc, 64'h114);
    check("waw_out_rd", out_rd, 7);
    check("waw_out_writes", out_writes_rd, 1);
    wb_valid = 0;
    issue(64'h118, 5'd7, 5'd0, 5'd0, 1'b0);
    #1 check("set_wins_busy7", in_ready, 0);
    wb_valid = 1; wb_rd = 5'd7; wb_data = 64'h78;
    tick();
    clear_inputs();
    tick();

    // Back-pressure: bundle holds while out_ready is low.
    issue(64'h200, 5'd1, 5'd0, 5'd0, 1'b0);
    rf_out1 = 64'hAB;
    tick();
    out_ready = 0;
    issue(64'h300, 5'd2, 5'd0, 5'd0, 1'b0);
    rf_out1 = 64'h0; rf_out2 = 64'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d_in_ready", c), in_ready, 0);
      check($sformatf("bp%0d_out_valid", c), out_valid, 1);
      check($sformatf("bp%0d_out_pc", c), out_pc, 64'h200);
      check($sformatf("bp%0d_out_rs1", c), out_rs1_val, 64'hAB);
      tick();
    end
    out_ready = 1;
    #1 check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_next_pc", out_pc, 64'h300);
    clear_inputs();

    // Flush drops an in-flight write to x9 and refuses a coincident instruction.
    issue(64'h400, 5'd0, 5'd0, 5'd9, 1'b1);
    tick();
    flush = 1;
    issue(64'h500, 5'd0, 5'd0, 5'd0, 1'b0);
    #1 check("flush_in_ready", in_ready, 0);
    tick();
    check("flush_out_valid", out_valid, 0);
    flush = 0;
    issue(64'h504, 5'd9, 5'd0, 5'd0, 1'b0);
    rf_out1 = 64'h99;
    #1 check("flush_busy9_cleared", in_ready, 1);
    tick();
    check("flush_next_pc", out_pc, 64'h504);
    check("flush_next_valid", out_valid, 1);
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
